// File: rtl/spi_cmd_bridge_pkg.sv
// Shared opcodes, constant reply bytes and FSM state encoding for the SPI command bridge.
package spi_cmd_bridge_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_READ  = 8'h02;
  localparam logic [7:0] CMD_ID    = 8'h9F;
  localparam logic [7:0] ID_BYTE   = 8'h5A;

  typedef enum logic [2:0] {
    ST_CMD       = 3'd0,
    ST_ADDR      = 3'd1,
    ST_WR_DATA   = 3'd2,
    ST_WR_BUSY   = 3'd3,
    ST_RD_FETCH  = 3'd4,
    ST_RD_STREAM = 3'd5,
    ST_DISCARD   = 3'd6
  } state_t;

endpackage

// File: rtl/spi_cmd_bridge_cdc_toggle_sync.sv
// Multi-flop synchroniser for a signal from the SPI domain; optionally turns
// each level change of a toggle into a one-cycle strobe.
module cdc_toggle_sync #(
  parameter int SYNC_STAGES = 2,
  parameter bit EDGE_DETECT = 1'b1,
  parameter bit RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic strobe
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      hist_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level  = sync_q[SYNC_STAGES-1];
  assign strobe = EDGE_DETECT ? (level ^ hist_q) : 1'b0;

endmodule

// File: rtl/spi_cmd_bridge.sv
// Decodes SPI command frames (opcode, address, data stream) into cart-bus
// memory transactions and supplies the next MISO byte to the SPI slave.
module spi_cmd_bridge
  import spi_cmd_bridge_pkg::*;
#(
  parameter int          ADDR_W      = 24,
  parameter int          SYNC_STAGES = 2,
  parameter logic [7:0]  IDLE_BYTE   = 8'hFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_cs,
  input  logic [7:0]        rx_byte,
  input  logic              rx_toggle,
  output logic [7:0]        tx_byte,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata,
  output logic              overrun,
  output logic [2:0]        dbg_state
);

  localparam int ADDR_BYTES = ADDR_W / 8;

  logic              rx_stb;
  logic              rx_lvl;
  logic              cs_lvl;
  logic              cs_unused;
  logic [7:0]        rx_hold;
  logic              byte_vld;
  logic              byte_ok;
  state_t            state;
  logic              is_write;
  logic              skip_dummy;
  logic [3:0]        byte_cnt;
  logic [ADDR_W-1:0] addr_reg;
  logic [ADDR_W-1:0] addr_inc;

  cdc_toggle_sync #(
    .SYNC_STAGES(SYNC_STAGES),
    .EDGE_DETECT(1'b1),
    .RESET_VAL  (1'b0)
  ) u_rx_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (rx_toggle),
    .level (rx_lvl),
    .strobe(rx_stb)
  );

  // Chip-select resets to "deselected" so the bridge idles aborted until the host drives it low.
  cdc_toggle_sync #(
    .SYNC_STAGES(SYNC_STAGES),
    .EDGE_DETECT(1'b0),
    .RESET_VAL  (1'b1)
  ) u_cs_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (spi_cs),
    .level (cs_lvl),
    .strobe(cs_unused)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_hold  <= 8'h00;
      byte_vld <= 1'b0;
    end else begin
      byte_vld <= rx_stb;
      if (rx_stb) rx_hold <= rx_byte;
    end
  end

  // Bus handshake: mem_req rises with mem_we/mem_addr/mem_wdata stable and stays
  // high until mem_ack is sampled high; mem_ack is only honoured while mem_req is high.
  assign byte_ok   = byte_vld && !mem_req;
  assign addr_inc  = addr_reg + {{(ADDR_W-1){1'b0}}, 1'b1};
  assign dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_CMD;
      tx_byte    <= IDLE_BYTE;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= 8'h00;
      overrun    <= 1'b0;
      is_write   <= 1'b0;
      skip_dummy <= 1'b0;
      byte_cnt   <= 4'd0;
      addr_reg   <= '0;
    end else begin
      overrun <= 1'b0;
      if (cs_lvl) begin
        // Abort: any in-flight request still finishes; its read data is dropped.
        tx_byte <= IDLE_BYTE;
        if (!mem_req || mem_ack) begin
          mem_req <= 1'b0;
          state   <= ST_CMD;
        end
      end else begin
        if (byte_vld && mem_req) overrun <= 1'b1;
        case (state)
          ST_CMD: begin
            if (byte_ok) begin
              byte_cnt <= 4'd0;
              case (rx_hold)
                CMD_WRITE: begin
                  is_write <= 1'b1;
                  state    <= ST_ADDR;
                end
                CMD_READ: begin
                  is_write <= 1'b0;
                  state    <= ST_ADDR;
                end
                CMD_ID: begin
                  tx_byte <= ID_BYTE;
                  state   <= ST_DISCARD;
                end
                default: state <= ST_DISCARD;
              endcase
            end
          end
          ST_ADDR: begin
            if (byte_ok) begin
              addr_reg <= {addr_reg[ADDR_W-9:0], rx_hold};
              byte_cnt <= byte_cnt + 4'd1;
              if (byte_cnt == 4'(ADDR_BYTES - 1)) begin
                state      <= is_write ? ST_WR_DATA : ST_RD_FETCH;
                skip_dummy <= 1'b1;
              end
            end
          end
          ST_WR_DATA: begin
            if (byte_ok) begin
              mem_req   <= 1'b1;
              mem_we    <= 1'b1;
              mem_addr  <= addr_reg;
              mem_wdata <= rx_hold;
              state     <= ST_WR_BUSY;
            end
          end
          ST_WR_BUSY: begin
            if (mem_ack) begin
              mem_req  <= 1'b0;
              addr_reg <= addr_inc;
              state    <= ST_WR_DATA;
            end
          end
          ST_RD_FETCH: begin
            if (!mem_req) begin
              mem_req  <= 1'b1;
              mem_we   <= 1'b0;
              mem_addr <= addr_reg;
            end else if (mem_ack) begin
              mem_req  <= 1'b0;
              tx_byte  <= mem_rdata;
              addr_reg <= addr_inc;
              state    <= ST_RD_STREAM;
            end
          end
          ST_RD_STREAM: begin
            // The first byte after the address is the host's dummy turnaround byte.
            if (byte_ok) begin
              if (skip_dummy) skip_dummy <= 1'b0;
              else            state      <= ST_RD_FETCH;
            end
          end
          ST_DISCARD: ;
          default: state <= ST_CMD;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_cmd_bridge.sv
// Randomised scoreboard bench for spi_cmd_bridge: SPI host driver, memory responder and request monitor.
module tb_spi_cmd_bridge;
  import spi_cmd_bridge_pkg::*;

  localparam int BYTE_GAP = 64;
  localparam int TW       = 33;

  logic        clk = 1'b0;
  logic        rst;
  logic        spi_cs;
  logic [7:0]  rx_byte;
  logic        rx_toggle;
  logic [7:0]  tx_byte;
  logic        mem_req;
  logic        mem_we;
  logic [23:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic        overrun;
  logic [2:0]  dbg_state;

  int n_vec     = 0;
  int n_err     = 0;
  int ovr_cnt   = 0;
  int exp_ovr   = 0;
  int ack_delay = 3;

  logic [TW-1:0] exp_q[$];
  logic [7:0]    data_q[$];
  logic [TW-1:0] mon_got;
  logic [TW-1:0] mon_exp;
  logic          req_q = 1'b0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  spi_cmd_bridge #(
    .ADDR_W     (24),
    .SYNC_STAGES(2),
    .IDLE_BYTE  (8'hFF)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .spi_cs   (spi_cs),
    .rx_byte  (rx_byte),
    .rx_toggle(rx_toggle),
    .tx_byte  (tx_byte),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata),
    .overrun  (overrun),
    .dbg_state(dbg_state)
  );

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  // Read data the memory returns for an address (0x10->11, 0x11->22, 0x12->33, ...).
  function automatic logic [7:0] rom(input logic [23:0] a);
    logic [7:0] v;
    v = (a[7:0] - 8'h0F) * 8'h11;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- memory responder ----------------
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (mem_req && !rst) begin
        repeat (ack_delay) @(negedge clk);
        mem_ack   = 1'b1;
        mem_rdata = rom(mem_addr);
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = 8'h00;
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (overrun) ovr_cnt++;
    if (mem_req && !req_q) begin
      mon_got = {mem_we, mem_addr, (mem_we ? mem_wdata : 8'h00)};
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_req: got we=%b addr=%h data=%h expected no request",
                 mem_we, mem_addr, mem_wdata);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          n_err++;
          $display("FAIL mem_txn: got we=%b addr=%h data=%h expected we=%b addr=%h data=%h",
                   mon_got[32], mon_got[31:8], mon_got[7:0],
                   mon_exp[32], mon_exp[31:8], mon_exp[7:0]);
        end
      end
    end
    req_q = mem_req;
  end

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge clk);
    #2;
    rx_byte   = b;
    rx_toggle = ~rx_toggle;
    cycles(gap);
  endtask

  task automatic send_addr(input logic [23:0] a, input int last_gap);
    send_byte(a[23:16], BYTE_GAP);
    send_byte(a[15:8], BYTE_GAP);
    send_byte(a[7:0], last_gap);
  endtask

  task automatic frame_start();
    spi_cs = 1'b0;
    cycles(4);
  endtask

  task automatic frame_end();
    spi_cs = 1'b1;
    cycles(6);
    check("idle_tx", tx_byte, 8'hFF);
    check("idle_state", dbg_state, ST_CMD);
  endtask

  task automatic do_write(input logic [23:0] a);
    logic [23:0] wa;
    frame_start();
    send_byte(CMD_WRITE, BYTE_GAP);
    send_addr(a, BYTE_GAP);
    for (int i = 0; i < data_q.size(); i++) begin
      wa = a + 24'(i);
      exp_q.push_back({1'b1, wa, data_q[i]});
      send_byte(data_q[i], BYTE_GAP);
    end
    frame_end();
  endtask

  task automatic do_read(input logic [23:0] a, input int n);
    logic [23:0] ra;
    for (int k = 0; k <= n; k++) begin
      ra = a + 24'(k);
      exp_q.push_back({1'b0, ra, 8'h00});
    end
    frame_start();
    send_byte(CMD_READ, BYTE_GAP);
    send_addr(a, BYTE_GAP);
    check("rd_first_tx", tx_byte, rom(a));
    send_byte(8'($urandom), BYTE_GAP);
    check("rd_dummy_tx", tx_byte, rom(a));
    for (int k = 1; k <= n; k++) begin
      send_byte(8'($urandom), BYTE_GAP);
      ra = a + 24'(k);
      check("rd_stream_tx", tx_byte, rom(ra));
    end
    frame_end();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [23:0] a;
    rst       = 1'b1;
    spi_cs    = 1'b1;
    rx_toggle = 1'b0;
    rx_byte   = 8'h00;
    cycles(3);
    check("rst_tx", tx_byte, 8'hFF);
    check("rst_req", mem_req, 1'b0);
    check("rst_we", mem_we, 1'b0);
    check("rst_addr", mem_addr, 24'h0);
    check("rst_wdata", mem_wdata, 8'h00);
    check("rst_overrun", overrun, 1'b0);
    check("rst_state", dbg_state, ST_CMD);
    rst = 1'b0;
    cycles(4);
    check("post_rst_state", dbg_state, ST_CMD);

    // Directed write and read from the reference frames
    data_q = '{8'hAA, 8'hBB};
    do_write(24'h123456);
    do_read(24'h000010, 2);

    // ID command: reply byte, no memory traffic
    frame_start();
    send_byte(CMD_ID, BYTE_GAP);
    check("id_tx", tx_byte, ID_BYTE);
    send_byte(8'h00, BYTE_GAP);
    check("id_tx_held", tx_byte, ID_BYTE);
    frame_end();

    // Unknown opcode is ignored for the rest of the frame
    frame_start();
    send_byte(8'h37, BYTE_GAP);
    send_byte(8'h01, BYTE_GAP);
    send_byte(8'h02, BYTE_GAP);
    check("unk_tx", tx_byte, 8'hFF);
    check("unk_state", dbg_state, ST_DISCARD);
    frame_end();

    // Address wrap
    data_q = '{8'h3C, 8'hC3};
    do_write(24'hFFFFFF);

    // Overrun: second byte lands while the first write is still unacknowledged
    frame_start();
    send_byte(CMD_WRITE, BYTE_GAP);
    send_addr(24'h00ABCD, BYTE_GAP);
    ack_delay = 100;
    exp_q.push_back({1'b1, 24'h00ABCD, 8'h5E});
    send_byte(8'h5E, BYTE_GAP);
    exp_ovr++;
    send_byte(8'hE5, 8);
    cycles(100);
    ack_delay = 3;
    check("overrun_cnt", ovr_cnt, exp_ovr);
    exp_q.push_back({1'b1, 24'h00ABCE, 8'h77});
    send_byte(8'h77, BYTE_GAP);
    frame_end();

    // Abort while a request is outstanding: it completes, then the FSM idles
    frame_start();
    send_byte(CMD_WRITE, BYTE_GAP);
    send_addr(24'h400000, BYTE_GAP);
    ack_delay = 20;
    exp_q.push_back({1'b1, 24'h400000, 8'h99});
    send_byte(8'h99, 8);
    spi_cs = 1'b1;
    cycles(4);
    check("abort_req_held", mem_req, 1'b1);
    for (int i = 0; i < 200 && mem_req; i++) @(negedge clk);
    check("abort_req_done", mem_req, 1'b0);
    cycles(2);
    check("abort_state", dbg_state, ST_CMD);
    check("abort_tx", tx_byte, 8'hFF);
    ack_delay = 3;
    cycles(30);

    // Asynchronous reset in the middle of a read
    ack_delay = 20;
    frame_start();
    exp_q.push_back({1'b0, 24'h000020, 8'h00});
    send_byte(CMD_READ, BYTE_GAP);
    send_addr(24'h000020, 10);
    check("rst_mid_req_pre", mem_req, 1'b1);
    #3;
    rst       = 1'b1;
    rx_toggle = 1'b0;
    spi_cs    = 1'b1;
    #1;
    check("rst_mid_req", mem_req, 1'b0);
    check("rst_mid_tx", tx_byte, 8'hFF);
    check("rst_mid_state", dbg_state, ST_CMD);
    cycles(40);
    rst       = 1'b0;
    ack_delay = 3;
    cycles(4);
    data_q = '{8'h42};
    do_write(24'h0F0F0F);

    // Randomised frames
    for (int f = 0; f < 8; f++) begin
      ack_delay = $urandom_range(1, 6);
      if ($urandom_range(0, 2) == 0) a = 24'hFFFFFF - 24'($urandom_range(0, 2));
      else                          a = 24'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        data_q.delete();
        for (int i = 0; i < $urandom_range(1, 4); i++) data_q.push_back(8'($urandom));
        do_write(a);
      end else begin
        do_read(a, $urandom_range(1, 3));
      end
    end

    cycles(20);
    check("exp_q_drained", exp_q.size(), 0);
    check("overrun_total", ovr_cnt, exp_ovr);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
